// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}; the decimal point is added by the top.

package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.

module hex7seg_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_8;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_8;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit common-anode display driver with per-digit blanking gap.
// Inputs are snapshotted once per frame so a digit never shows a half-updated value.

module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned DIV_BIT      = 17,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] clkdiv,
    input  logic [31:0] hex,
    input  logic [7:0]  point,
    input  logic [7:0]  digit_en,
    output logic [7:0]  an,
    output logic [7:0]  seg_n,
    output logic        frame_done
);

    // One digit slot is 2^(DIV_BIT+1) cycles, so the blank count always fits in this width.
    localparam int unsigned        CntW    = DIV_BIT + 1;
    localparam logic [CntW-1:0]    CntLoad = CntW'(BLANK_CYCLES);
    localparam logic [CntW-1:0]    CntOne  = CntW'(1);

    state_t          state_q, state_d;
    logic            bit_q;
    logic            tick;
    logic [2:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     sh_hex_q, sh_hex_d;
    logic [7:0]      sh_point_q, sh_point_d;
    logic [7:0]      sh_en_q, sh_en_d;
    logic [7:0]      an_q, an_d;
    logic [7:0]      seg_q, seg_d;
    logic            fd_q, fd_d;
    logic            snap;
    logic [3:0]      cur_nibble;
    logic [6:0]      dec_seg;
    logic            unused_clkdiv;

    assign unused_clkdiv = ^clkdiv;

    assign tick = clkdiv[DIV_BIT] & ~bit_q;

    assign cur_nibble = sh_hex_q[{idx_q, 2'b00} +: 4];

    hex7seg_dec u_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        sh_hex_d   = sh_hex_q;
        sh_point_d = sh_point_q;
        sh_en_d    = sh_en_q;
        an_d       = an_q;
        seg_d      = seg_q;
        fd_d       = 1'b0;
        snap       = 1'b0;

        unique case (state_q)
            IDLE: begin
                an_d  = AN_OFF;
                seg_d = SEG_OFF;
                if (tick) begin
                    snap    = 1'b1;
                    idx_d   = 3'd0;
                    cnt_d   = CntLoad;
                    state_d = BLANK;
                end
            end

            BLANK: begin
                // Ticks landing here are deliberately dropped.
                an_d  = AN_OFF;
                seg_d = SEG_OFF;
                if (cnt_q <= CntOne) begin
                    cnt_d   = '0;
                    state_d = DRIVE;
                    if (sh_en_q[idx_q]) begin
                        an_d  = ~(8'h01 << idx_q);
                        seg_d = {~sh_point_q[idx_q], dec_seg};
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end

            DRIVE: begin
                if (tick) begin
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = CntLoad;
                    state_d = BLANK;
                    an_d    = AN_OFF;
                    seg_d   = SEG_OFF;
                    if (idx_q == 3'd7) begin
                        snap = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                an_d    = AN_OFF;
                seg_d   = SEG_OFF;
            end
        endcase

        if (snap) begin
            sh_hex_d   = hex;
            sh_point_d = point;
            sh_en_d    = digit_en;
            fd_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_q      <= 1'b1;
            idx_q      <= 3'd0;
            cnt_q      <= '0;
            sh_hex_q   <= '0;
            sh_point_q <= '0;
            sh_en_q    <= '0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_OFF;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= clkdiv[DIV_BIT];
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            sh_hex_q   <= sh_hex_d;
            sh_point_q <= sh_point_d;
            sh_en_q    <= sh_en_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            fd_q       <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg_n      = seg_q;
    assign frame_done = fd_q;

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It consumes the free-running `clkdiv[31:0]` bus and uses rising edges of one selected bit as the digit-advance strobe. Each frame it snapshots a 32-bit hex value, decimal points and digit enables, and inserts a blanking gap between digits to suppress ghosting. It sits downstream of the clock divider and shows score/debug values.

## Interface
- `DIV_BIT`, default 17: index of the `clkdiv` bit whose rising edge advances the digit. At 100 MHz that is one step per 2.62 ms.
- `BLANK_CYCLES`, default 64: number of `clk` cycles with all anodes off between digits. Must be ≥1 and < 2^(DIV_BIT+1).
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clkdiv` in 32: free-running divider count, synchronous to `clk`.
- `hex` in 32: digit i is `hex[4i+3:4i]`; digit 0 is rightmost.
- `point` in 8: active-high decimal point per digit.
- `digit_en` in 8: active-high per digit; a disabled digit keeps its anode off during its slot.
- `an` out 8: active-low anode select.
- `seg_n` out 8: active-low segments, ordered {dp,g,f,e,d,c,b,a}.
- `frame_done` out 1: one-cycle pulse when a new snapshot is taken.

## Operation
- Edge detect: register `bit_q <= clkdiv[DIV_BIT]`. `bit_q` resets to 1. `tick = clkdiv[DIV_BIT] & ~bit_q`. A bit already high at reset release does not tick.
- States:
  - IDLE (reset): on `tick`, snapshot `hex`/`point`/`digit_en` into shadow registers, set idx=0, pulse `frame_done`, load blank counter, go to BLANK.
  - BLANK: `an`=FF, `seg_n`=FF. The counter counts down from BLANK_CYCLES. On the edge where it expires, go to DRIVE.
  - DRIVE: if shadow `digit_en[idx]`, then `an` = ~(1<<idx) and `seg_n` = decode(shadow nibble idx) with bit7 = ~shadow `point[idx]`. Otherwise `an`=FF and `seg_n`=FF. On `tick`: idx ← idx+1 mod 8, reload the counter, go to BLANK.
- Wrap: on the DRIVE→BLANK transition with idx=7, idx becomes 0. On the same edge the shadow registers re-snapshot the inputs and `frame_done` pulses. Input changes are therefore visible only at frame boundaries, with no tearing.
- A `tick` arriving in BLANK is dropped. It is not queued.
- Decode, active-low, bit7=1:
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8
  - 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E
- `rst_n` low at any time: immediately `an`=FF, `seg_n`=FF, `frame_done`=0, idx=0, state IDLE, shadow registers 0, counter 0, `bit_q`=1.

## Timing
- All outputs are registered.
- `tick` is combinational. The state transition and the new `an`/`seg_n` values take effect on the same `clk` edge at which `tick`=1, which is 1 edge after `clkdiv[DIV_BIT]` rises.
- Anodes stay off for exactly BLANK_CYCLES edges after that edge. The digit drives on the following edge.
- DRIVE duration per digit = 2^(DIV_BIT+1) − BLANK_CYCLES cycles in steady state. Full frame = 8·2^(DIV_BIT+1) cycles.
- `frame_done` is high for exactly one cycle, coincident with the first BLANK cycle of digit 0.
- At most one anode is low in any cycle.

## Structure
- Package `seg7_pkg` holds:
  - state enum {IDLE, BLANK, DRIVE}
  - `SEG_OFF` = 8'hFF and `AN_OFF` = 8'hFF
  - the 16-entry decode constants
- Sub-module `hex7seg_dec`: purely combinational nibble → 7-bit active-low pattern, instantiated once and fed by the idx-selected shadow nibble.
- The top holds the edge detect, FSM, blank counter, idx and shadow registers.

## Test plan
Parameters DIV_BIT=3 (tick every 16 cycles), BLANK_CYCLES=4; `clkdiv` driven by a counter.

1. Reset: hold `rst_n`=0 → `an`=FF, `seg_n`=FF, `frame_done`=0. Release with `clkdiv[3]` already 1 → no tick until its next rising edge.
2. Frame scan: `hex`=32'h76543210, `point`=0, `digit_en`=FF → digits 0..7 in order; digit 0 shows C0, digit 1 F9, …, digit 7 F8. Each digit is preceded by exactly 4 cycles of `an`=FF and driven 12 cycles. `frame_done` pulses every 128 cycles.
3. Snapshot: change `hex` to 32'hFFFFFFFF while digit 3 is driving → digits 3..7 still show old values. The next frame shows 8E on all digits.
4. Enables and points: `digit_en`=8'h0F, `point`=8'h01, `hex`=0 → digit 0 `seg_n`=40; digits 1–3 show C0; `an` stays FF in slots 4–7.
5. Reset mid-operation: assert `rst_n` during DRIVE of digit 5 → same-cycle outputs FF. After release the scan restarts at digit 0 with `frame_done`.
6. Invariant checks throughout: one-hot-low `an`, never two anodes low, no anode low within BLANK_CYCLES of a change in idx.
